// File: rtl/hwpe_stream_sink_realign_ofs_pkg.sv
// hwpe_stream_sink_realign_ofs_pkg: shared types for the sink-side offset realigner
// Provides the FSM state encoding, a packed control descriptor {offset, len}
// and REALIGN_OFS, the reference descriptor reused as a canned packet.
package hwpe_stream_sink_realign_ofs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        BODY,
        FLUSH,
        DONE
    } realign_state_e;

    typedef struct packed {
        logic [7:0]  offset;
        logic [15:0] len;
    } ctrl_realign_ofs_t;

    localparam ctrl_realign_ofs_t REALIGN_OFS = '{offset: 8'd1, len: 16'd2};

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// hwpe_stream_intf_stream: valid/ready stream carrying a data word and byte strobes
// master drives valid/data/strb and samples ready; slave is the mirror image.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, data, strb, input ready);
    modport slave (input valid, data, strb, output ready);

endinterface

// File: rtl/hwpe_stream_realign_merge.sv
// hwpe_stream_realign_merge: combinational byte shifter building one realigned word
// Ports: cur (current input word), carry (previous input word), ofs (byte offset),
// first (mask the carry half), flush (emit only the carry half) -> data, strb.
module hwpe_stream_realign_merge #(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned N = DATA_WIDTH / 8,
    localparam int unsigned OW = $clog2(N)
) (
    input  logic [DATA_WIDTH-1:0] cur,
    input  logic [DATA_WIDTH-1:0] carry,
    input  logic [OW-1:0]         ofs,
    input  logic                  first,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data,
    output logic [N-1:0]          strb
);

    logic [OW:0]  back;
    logic [N-1:0] lo;

    // carry bytes N-o..N-1 land in output bytes 0..o-1; o=0 shifts the carry out entirely
    assign back = (OW + 1)'(N) - {1'b0, ofs};
    assign lo   = ~({N{1'b1}} << ofs);
    assign data = (flush ? '0 : cur << {ofs, 3'b000}) | (first ? '0 : carry >> {back, 3'b000});
    assign strb = flush ? lo : first ? ~lo : '1;

endmodule

// File: rtl/hwpe_stream_sink_realign_ofs.sv
// hwpe_stream_sink_realign_ofs: self-sequencing realigner placing aligned words at a byte offset
// Ports: clk_i, rst_i (sync, active-high), clear_i (soft clear), start_i/offset_i/len_i
// (packet descriptor), busy_o, done_o (one-cycle completion pulse),
// stream_i (aligned input, strb ignored), stream_o (realigned output with strobes).
module hwpe_stream_sink_realign_ofs
    import hwpe_stream_sink_realign_ofs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    localparam int unsigned N = DATA_WIDTH / 8,
    localparam int unsigned OW = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [OW-1:0]        offset_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    hwpe_stream_intf_stream.slave  stream_i,
    hwpe_stream_intf_stream.master stream_o
);

    realign_state_e        state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, len_q;
    logic [OW-1:0]         ofs_q;
    logic [DATA_WIDTH-1:0] carry_q, mrg_data;
    logic [N-1:0]          mrg_strb;
    logic                  stream_phase, in_hs, last, out_valid, in_ready, drive;

    assign stream_phase = state_q == FIRST || state_q == BODY;
    assign in_hs        = stream_phase && stream_i.valid && stream_o.ready;
    assign last         = cnt_q == len_q - LEN_WIDTH'(1);
    assign drive        = stream_phase || state_q == FLUSH;

    hwpe_stream_realign_merge #(.DATA_WIDTH(DATA_WIDTH)) i_merge (
        .cur   (stream_i.data),
        .carry (carry_q),
        .ofs   (ofs_q),
        .first (state_q == FIRST),
        .flush (state_q == FLUSH),
        .data  (mrg_data),
        .strb  (mrg_strb)
    );

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            IDLE: if (start_i) state_d = len_i == '0 ? DONE : FIRST;
            FIRST, BODY: begin
                out_valid = stream_i.valid;
                in_ready  = stream_o.ready;
                if (in_hs) state_d = !last ? BODY : ofs_q != '0 ? FLUSH : DONE;
            end
            FLUSH: begin
                out_valid = 1'b1;
                if (stream_o.ready) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            ofs_q   <= '0;
            carry_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i && len_i != '0) begin
                ofs_q <= offset_i;
                len_q <= len_i;
                cnt_q <= '0;
            end
            if (in_hs) begin
                cnt_q   <= cnt_q + LEN_WIDTH'(1);
                carry_q <= stream_i.data;
            end
        end
    end

    assign stream_o.valid = out_valid;
    assign stream_i.ready = in_ready;
    // outside the streaming states the bus is held at zero rather than showing stale merges
    assign stream_o.data  = drive ? mrg_data : '0;
    assign stream_o.strb  = drive ? mrg_strb : '0;
    assign busy_o         = state_q != IDLE;
    assign done_o         = state_q == DONE;

endmodule

// File: tb/tb_hwpe_stream_sink_realign_ofs.sv
// tb_hwpe_stream_sink_realign_ofs: randomized self-checking bench for the offset realigner
module tb_hwpe_stream_sink_realign_ofs;
    import hwpe_stream_sink_realign_ofs_pkg::*;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk_i    = 1'b0;
    logic          rst_i    = 1'b1;
    logic          clear_i  = 1'b0;
    logic          start_i  = 1'b0;
    logic [1:0]    offset_i = '0;
    logic [LW-1:0] len_i    = '0;
    logic          busy_o, done_o;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) out_if ();

    hwpe_stream_sink_realign_ofs #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .start_i  (start_i),
        .offset_i (offset_i),
        .len_i    (len_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .stream_i (in_if),
        .stream_o (out_if)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    logic [31:0] in_words[$];
    logic [31:0] exp_d[$];
    logic [31:0] got_d[$];
    logic [3:0]  exp_s[$];
    logic [3:0]  got_s[$];
    int n_in, done_cyc, done_cnt, last_hs_cyc, unstable;

    // input byte i of the packet lands at destination byte o+i; everything else is unwritten
    function automatic void build_exp(input int o, input int l);
        int nw;
        nw = (o + l * 4 + 3) / 4;
        exp_d.delete();
        exp_s.delete();
        for (int k = 0; k < nw; k++) begin
            logic [31:0] d;
            logic [31:0] w;
            logic [3:0]  s;
            d = '0;
            s = '0;
            for (int j = 0; j < 4; j++) begin
                int p;
                p = k * 4 + j - o;
                if (p >= 0 && p < l * 4) begin
                    w = in_words[p / 4];
                    d[8 * j +: 8] = w[8 * (p % 4) +: 8];
                    s[j] = 1'b1;
                end
            end
            exp_d.push_back(d);
            exp_s.push_back(s);
        end
    endfunction

    // drives one packet from in_words, collects output handshakes, tracks stalls and done
    task automatic run_pkt(input int o, input int l, input int stall, input int gap, input int restart);
        int cyc = 0;
        int idx = 0;
        bit pend = 0;
        bit p_stall = 0;
        logic [31:0] p_d = '0;
        logic [3:0]  p_s = '0;
        got_d.delete();
        got_s.delete();
        done_cyc = -1;
        done_cnt = 0;
        last_hs_cyc = -1;
        unstable = 0;
        while (cyc < 400 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
            start_i  = (cyc == 0) || (cyc == restart);
            offset_i = (cyc == 0) ? 2'(o) : 2'd3;
            len_i    = (cyc == 0) ? LW'(l) : LW'(5);
            if (!pend) begin
                pend = idx < l && $urandom_range(99) >= gap;
                in_if.valid = pend;
                in_if.data  = pend ? in_words[idx] : $urandom;
            end
            in_if.strb   = 4'($urandom);
            out_if.ready = $urandom_range(99) >= stall;
            @(negedge clk_i);
            if (p_stall && (!out_if.valid || out_if.data !== p_d || out_if.strb !== p_s)) unstable++;
            if (out_if.valid && out_if.ready) begin
                got_d.push_back(out_if.data);
                got_s.push_back(out_if.strb);
                last_hs_cyc = cyc;
            end
            p_stall = out_if.valid && !out_if.ready;
            p_d = out_if.data;
            p_s = out_if.strb;
            if (in_if.valid && in_if.ready) begin
                idx++;
                pend = 0;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        start_i = 1'b0;
        in_if.valid = 1'b0;
        out_if.ready = 1'b0;
        n_in = idx;
    endtask

    task automatic test_reset();
        start_i = 1'b1;
        len_i = LW'(3);
        in_if.valid = 1'b1;
        in_if.data = $urandom;
        in_if.strb = '1;
        out_if.ready = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_if.valid); end
        checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_if.ready); end
        checks++; if (out_if.data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_if.data); end
        checks++; if (out_if.strb !== 4'h0) begin errors++; $display("FAIL reset_strb: got %b want 0", out_if.strb); end
        in_if.valid = 1'b0;
        out_if.ready = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_offset1(input string name);
        logic [31:0] ed[3] = '{32'h33221100, 32'h77665544, 32'h00000088};
        logic [3:0]  es[3] = '{4'b1110, 4'b1111, 4'b0001};
        in_words = '{32'h44332211, 32'h88776655};
        run_pkt(int'(REALIGN_OFS.offset), int'(REALIGN_OFS.len), 0, 0, -1);
        checks++; if (got_d.size() !== 3) begin errors++; $display("FAIL %s count: got %0d want 3", name, got_d.size()); end
        for (int k = 0; k < 3 && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] !== ed[k] || got_s[k] !== es[k]) begin
                errors++;
                $display("FAIL %s word%0d: got %h/%b want %h/%b", name, k, got_d[k], got_s[k], ed[k], es[k]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_hs_cyc + 1) begin
            errors++;
            $display("FAIL %s done: got %0d pulses at cyc %0d want 1 at cyc %0d", name, done_cnt, done_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_single();
        in_words = '{32'hDDCCBBAA};
        run_pkt(3, 1, 0, 0, -1);
        checks++; if (got_d.size() !== 2) begin errors++; $display("FAIL single count: got %0d want 2", got_d.size()); end
        if (got_d.size() >= 2) begin
            checks++;
            if (got_d[0] !== 32'hAA000000 || got_s[0] !== 4'b1000) begin
                errors++;
                $display("FAIL single word0: got %h/%b want aa000000/1000", got_d[0], got_s[0]);
            end
            checks++;
            if (got_d[1] !== 32'h00DDCCBB || got_s[1] !== 4'b0111) begin
                errors++;
                $display("FAIL single word1: got %h/%b want 00ddccbb/0111", got_d[1], got_s[1]);
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_stream(input string name, input int o, input int l, input int stall, input int gap, input int restart);
        in_words.delete();
        for (int i = 0; i < l; i++) in_words.push_back($urandom);
        run_pkt(o, l, stall, gap, restart);
        build_exp(o, l);
        checks++;
        if (got_d.size() !== exp_d.size()) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, got_d.size(), exp_d.size());
        end
        for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k]) begin
                errors++;
                $display("FAIL %s word%0d: got %h/%b want %h/%b", name, k, got_d[k], got_s[k], exp_d[k], exp_s[k]);
            end
        end
        checks++; if (n_in !== l) begin errors++; $display("FAIL %s consumed: got %0d want %0d", name, n_in, l); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL %s stall_stability: got %0d changes want 0", name, unstable); end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_hs_cyc + 1) begin
            errors++;
            $display("FAIL %s done: got %0d pulses at cyc %0d want 1 at cyc %0d", name, done_cnt, done_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_abort();
        int hs = 0;
        int cyc = 0;
        int dones = 0;
        offset_i = 2'd1;
        len_i = LW'(8);
        start_i = 1'b1;
        in_if.valid = 1'b1;
        in_if.data = $urandom;
        out_if.ready = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        while (hs < 2 && cyc < 20) begin
            @(negedge clk_i);
            if (in_if.valid && in_if.ready) hs++;
            @(posedge clk_i);
            #1;
            in_if.data = $urandom;
            cyc++;
        end
        checks++; if (hs !== 2) begin errors++; $display("FAIL abort_handshakes: got %0d want 2", hs); end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", out_if.valid); end
        checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", in_if.ready); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_o); end
        in_if.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dones += done_o;
            @(negedge clk_i);
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", dones); end
        @(posedge clk_i);
        #1;
        test_offset1("after_abort");
    endtask

    task automatic test_clear();
        in_words.delete();
        for (int i = 0; i < 4; i++) in_words.push_back($urandom);
        offset_i = 2'd2;
        len_i = LW'(4);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        in_if.valid = 1'b1;
        in_if.data = in_words[0];
        out_if.ready = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_abort: got busy=%b valid=%b want 0/0", busy_o, out_if.valid);
        end
        in_if.valid = 1'b0;
        out_if.ready = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_len_zero();
        int seen = 0;
        offset_i = 2'd2;
        len_i = '0;
        start_i = 1'b1;
        in_if.valid = 1'b1;
        in_if.data = $urandom;
        out_if.ready = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(negedge clk_i);
        seen += out_if.valid + in_if.ready;
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL len0_done: got %b want 1", done_o); end
        @(negedge clk_i);
        seen += out_if.valid + in_if.ready;
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL len0_idle: got done=%b busy=%b want 0/0", done_o, busy_o);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL len0_traffic: got %0d want 0", seen); end
        in_if.valid = 1'b0;
        out_if.ready = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        in_if.valid = 1'b0;
        in_if.data = '0;
        in_if.strb = '0;
        out_if.ready = 1'b0;
        test_reset();
        test_offset1("offset1");
        test_stream("aligned", 0, 3, 0, 0, -1);
        test_single();
        for (int i = 0; i < 3; i++) test_stream("backpressure", 2, 4, 20, 0, -1);
        test_abort();
        test_clear();
        test_len_zero();
        test_stream("restart_ignored", 1, 2, 0, 0, 2);
        for (int i = 0; i < 8; i++) test_stream("random", $urandom_range(3), $urandom_range(1, 7), 30, 25, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
